// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V pipeline: datapath width, MEM-stage
// state encoding and the default data-memory timeout.
package misc_v_pkg;

    localparam int DATA_W          = 16;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads either a real instruction or a bubble;
// a bubble clears the control bits and leaves the data fields untouched.
module mem_wb_reg
    import misc_v_pkg::*;
#(
    parameter int DATA_W = misc_v_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              load_instr,
    input  logic              reg_write,
    input  logic              reg_store,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] rd,
    output logic              valid_q,
    output logic              reg_write_q,
    output logic              reg_store_q,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [DATA_W-1:0] mem_data_q,
    output logic [DATA_W-1:0] rd_q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_store_q  <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            rd_q         <= '0;
        end else if (load_instr) begin
            valid_q      <= 1'b1;
            reg_write_q  <= reg_write;
            reg_store_q  <= reg_store;
            alu_result_q <= alu_result;
            mem_data_q   <= mem_data;
            rd_q         <= rd;
        end else begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_store_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MISC-V memory stage: runs loads/stores over a req/ack data-memory port,
// stalls the front pipeline while an access is outstanding, drives MEM/WB.
module mem_access_stage
    import misc_v_pkg::*;
#(
    parameter int DATA_W  = misc_v_pkg::DATA_W,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRegWrite,
    input  logic              IMemWrite,
    input  logic              IMemRead,
    input  logic              IRegStore,
    input  logic [DATA_W-1:0] IALUResult,
    input  logic [DATA_W-1:0] I3rdArg,
    input  logic [DATA_W-1:0] IRd,
    output logic              DMemReq,
    output logic              DMemWE,
    output logic [DATA_W-1:0] DMemAddr,
    output logic [DATA_W-1:0] DMemWData,
    input  logic              DMemAck,
    input  logic [DATA_W-1:0] DMemRData,
    output logic              Stall,
    output logic              MemFault,
    output logic              OValid,
    output logic              ORegWrite,
    output logic              ORegStore,
    output logic [DATA_W-1:0] OALUResult,
    output logic [DATA_W-1:0] OMemData,
    output logic [DATA_W-1:0] ORd
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        wait_cnt;
    logic              held_reg_write;
    logic              held_reg_store;
    logic [DATA_W-1:0] held_rd;

    logic              memop;
    logic              timeout_hit;
    logic              wb_load;
    logic              wb_reg_write;
    logic              wb_reg_store;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_mem;
    logic [DATA_W-1:0] wb_rd;

    assign memop   = IMemRead | IMemWrite;
    assign DMemReq = (state_q == ACCESS);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        Stall        = 1'b0;
        timeout_hit  = 1'b0;
        wb_load      = 1'b0;
        wb_reg_write = IRegWrite;
        wb_reg_store = IRegStore;
        wb_alu       = IALUResult;
        wb_rd        = IRd;
        wb_mem       = '0;

        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    Stall   = 1'b1;
                    state_d = ACCESS;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ACCESS: begin
                // Retire from the copy captured at launch, not the live inputs.
                wb_reg_write = held_reg_write;
                wb_reg_store = held_reg_store;
                wb_alu       = DMemAddr;
                wb_rd        = held_rd;
                if (DMemAck) begin
                    state_d = IDLE;
                    wb_load = 1'b1;
                    wb_mem  = DMemWE ? '0 : DMemRData;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_d      = IDLE;
                    wb_load      = 1'b1;
                    wb_reg_write = 1'b0;
                    timeout_hit  = 1'b1;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            wait_cnt       <= '0;
            MemFault       <= 1'b0;
            DMemWE         <= 1'b0;
            DMemAddr       <= '0;
            DMemWData      <= '0;
            held_reg_write <= 1'b0;
            held_reg_store <= 1'b0;
            held_rd        <= '0;
        end else begin
            state_q <= state_d;
            if (timeout_hit) begin
                MemFault <= 1'b1;
            end
            if (state_q == IDLE && memop) begin
                wait_cnt       <= '0;
                DMemWE         <= IMemWrite;
                DMemAddr       <= IALUResult;
                DMemWData      <= I3rdArg;
                held_reg_write <= IRegWrite;
                held_reg_store <= IRegStore;
                held_rd        <= IRd;
            end else if (state_q == ACCESS && !DMemAck) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .CLK         (CLK),
        .Reset       (Reset),
        .load_instr  (wb_load),
        .reg_write   (wb_reg_write),
        .reg_store   (wb_reg_store),
        .alu_result  (wb_alu),
        .mem_data    (wb_mem),
        .rd          (wb_rd),
        .valid_q     (OValid),
        .reg_write_q (ORegWrite),
        .reg_store_q (ORegStore),
        .alu_result_q(OALUResult),
        .mem_data_q  (OMemData),
        .rd_q        (ORd)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random ops,
// each predicted per transaction from its type and the memory's ack delay.
module tb_mem_access_stage;

    localparam int TIMEOUT_T = 4;

    logic        CLK;
    logic        Reset;
    logic        IRegWrite;
    logic        IMemWrite;
    logic        IMemRead;
    logic        IRegStore;
    logic [15:0] IALUResult;
    logic [15:0] I3rdArg;
    logic [15:0] IRd;
    logic        DMemReq;
    logic        DMemWE;
    logic [15:0] DMemAddr;
    logic [15:0] DMemWData;
    logic        DMemAck;
    logic [15:0] DMemRData;
    logic        Stall;
    logic        MemFault;
    logic        OValid;
    logic        ORegWrite;
    logic        ORegStore;
    logic [15:0] OALUResult;
    logic [15:0] OMemData;
    logic [15:0] ORd;

    int   vectors;
    int   miscompares;
    logic fault_model;

    mem_access_stage #(
        .DATA_W (16),
        .TIMEOUT(TIMEOUT_T)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .IRegWrite (IRegWrite),
        .IMemWrite (IMemWrite),
        .IMemRead  (IMemRead),
        .IRegStore (IRegStore),
        .IALUResult(IALUResult),
        .I3rdArg   (I3rdArg),
        .IRd       (IRd),
        .DMemReq   (DMemReq),
        .DMemWE    (DMemWE),
        .DMemAddr  (DMemAddr),
        .DMemWData (DMemWData),
        .DMemAck   (DMemAck),
        .DMemRData (DMemRData),
        .Stall     (Stall),
        .MemFault  (MemFault),
        .OValid    (OValid),
        .ORegWrite (ORegWrite),
        .ORegStore (ORegStore),
        .OALUResult(OALUResult),
        .OMemData  (OMemData),
        .ORd       (ORd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from the current negedge to the negedge after it
    // retires. ack_at = ACCESS cycle (1-based) in which memory acks; values
    // outside 1..TIMEOUT_T mean memory never answers.
    task automatic run_op(input logic rw, input logic rs, input logic mr, input logic mw,
                          input logic [15:0] alu, input logic [15:0] arg3,
                          input logic [15:0] rd, input int ack_at,
                          input logic [15:0] rdata);
        int   n;
        logic fault;
        IRegWrite  = rw;
        IRegStore  = rs;
        IMemRead   = mr;
        IMemWrite  = mw;
        IALUResult = alu;
        I3rdArg    = arg3;
        IRd        = rd;
        if (!(mr | mw)) begin
            // A stray ack outside an access must have no effect.
            DMemAck   = 1'($urandom_range(0, 1));
            DMemRData = 16'($urandom);
            #1;
            check("nop_stall", 32'(Stall), 32'd0);
            check("nop_req", 32'(DMemReq), 32'd0);
            @(negedge CLK);
            DMemAck = 1'b0;
            check("nop_valid", 32'(OValid), 32'd1);
            check("nop_regwrite", 32'(ORegWrite), 32'(rw));
            check("nop_regstore", 32'(ORegStore), 32'(rs));
            check("nop_alu", 32'(OALUResult), 32'(alu));
            check("nop_rd", 32'(ORd), 32'(rd));
            check("nop_memdata", 32'(OMemData), 32'd0);
        end else begin
            fault = !(ack_at >= 1 && ack_at <= TIMEOUT_T);
            n     = fault ? TIMEOUT_T : ack_at;
            DMemAck = 1'b0;
            #1;
            check("launch_stall", 32'(Stall), 32'd1);
            check("launch_req", 32'(DMemReq), 32'd0);
            for (int k = 1; k <= n; k++) begin
                @(negedge CLK);
                // EX/MEM inputs wander during the access; the stage must ignore them.
                IRegWrite  = 1'($urandom);
                IRegStore  = 1'($urandom);
                IMemRead   = 1'($urandom);
                IMemWrite  = 1'($urandom);
                IALUResult = 16'($urandom);
                I3rdArg    = 16'($urandom);
                IRd        = 16'($urandom);
                DMemAck    = (k == ack_at);
                DMemRData  = (k == ack_at) ? rdata : 16'($urandom);
                check("bubble_valid", 32'(OValid), 32'd0);
                check("bubble_regwrite", 32'(ORegWrite), 32'd0);
                check("bubble_regstore", 32'(ORegStore), 32'd0);
                check("access_req", 32'(DMemReq), 32'd1);
                check("access_we", 32'(DMemWE), 32'(mw));
                check("access_addr", 32'(DMemAddr), 32'(alu));
                check("access_wdata", 32'(DMemWData), 32'(arg3));
                #1;
                check("access_stall", 32'(Stall), (k == n) ? 32'd0 : 32'd1);
            end
            @(negedge CLK);
            DMemAck     = 1'b0;
            fault_model = fault_model | fault;
            check("retire_valid", 32'(OValid), 32'd1);
            check("retire_regwrite", 32'(ORegWrite), fault ? 32'd0 : 32'(rw));
            check("retire_regstore", 32'(ORegStore), 32'(rs));
            check("retire_alu", 32'(OALUResult), 32'(alu));
            check("retire_rd", 32'(ORd), 32'(rd));
            check("retire_memdata", 32'(OMemData), (!fault && !mw) ? 32'(rdata) : 32'd0);
            check("retire_req", 32'(DMemReq), 32'd0);
        end
        check("memfault", 32'(MemFault), 32'(fault_model));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fault_model = 1'b0;
        Reset       = 1'b1;
        IRegWrite   = 1'b0;
        IRegStore   = 1'b0;
        IMemRead    = 1'b0;
        IMemWrite   = 1'b0;
        IALUResult  = '0;
        I3rdArg     = '0;
        IRd         = '0;
        DMemAck     = 1'b0;
        DMemRData   = '0;
        #1;
        check("rst_req", 32'(DMemReq), 32'd0);
        check("rst_we", 32'(DMemWE), 32'd0);
        check("rst_addr", 32'(DMemAddr), 32'd0);
        check("rst_wdata", 32'(DMemWData), 32'd0);
        check("rst_fault", 32'(MemFault), 32'd0);
        check("rst_valid", 32'(OValid), 32'd0);
        check("rst_alu", 32'(OALUResult), 32'd0);
        check("rst_rd", 32'(ORd), 32'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;

        // Directed: plain ALU op, 3-cycle load, 1-cycle store, both-set = write.
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0003, 0, 16'h0000);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0005, 3, 16'hBEEF);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h00AA, 16'h0000, 1, 16'h5555);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hC0DE, 16'h0007, 2, 16'h7777);
        // Ack in the last allowed cycle wins over the timeout.
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0002, TIMEOUT_T, 16'hA5A5);
        // Timeout, then the sticky flag survives later ops.
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0004, 0, 16'h0000);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0000, 16'h0009, 0, 16'h0000);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0006, 2, 16'h1111);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, TIMEOUT_T + 1)), 16'($urandom));
        end

        // Reset in the middle of an access, with MemFault already set.
        IRegWrite  = 1'b1;
        IRegStore  = 1'b1;
        IMemRead   = 1'b1;
        IMemWrite  = 1'b0;
        IALUResult = 16'h0300;
        IRd        = 16'h0001;
        repeat (2) @(negedge CLK);
        check("pre_rst_req", 32'(DMemReq), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        fault_model = 1'b0;
        check("mid_rst_req", 32'(DMemReq), 32'd0);
        check("mid_rst_addr", 32'(DMemAddr), 32'd0);
        check("mid_rst_we", 32'(DMemWE), 32'd0);
        check("mid_rst_fault", 32'(MemFault), 32'd0);
        check("mid_rst_valid", 32'(OValid), 32'd0);
        check("mid_rst_regwrite", 32'(ORegWrite), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0BAD, 16'h0000, 16'h000A, 0, 16'h0000);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h000B, 2, 16'h600D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
